sipo_deser_ctrl: RTL and testbench
==================================

SIPO_DESER_CTRL -- requirements
Module: sipo_deser_ctrl

Interface
REQ-001: Parameter NBITS, default 8, SHALL set the deserialized word width in bits (NBITS >= 2).
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: reset  input  1  SHALL be an asynchronous, active-low reset (asserted when 0).
REQ-004: in_val  input  1  SHALL indicate that in_bit carries a valid serial bit.
REQ-005: in_bit  input  1  SHALL be the serial data bit.
REQ-006: in_rdy  output  1  SHALL indicate the block accepts a bit this cycle.
REQ-007: flush  input  1  SHALL discard any partial or held word, synchronously.
REQ-008: out_val  output  1  SHALL indicate out_data holds a complete word.
REQ-009: out_rdy  input  1  SHALL indicate the consumer accepts out_data this cycle.
REQ-010: out_data  output  NBITS  SHALL be the parallel word (first-received bit in MSB).
REQ-011: count  output  clog2(NBITS)  SHALL report the number of bits captured in the current word.

Function
REQ-012: The FSM SHALL have states IDLE (count 0), SHIFT (0 < count < NBITS), FULL (word complete).
REQ-013: in_rdy SHALL be 1 in IDLE and SHIFT, and 0 in FULL; it is a function of state only.
REQ-014: A bit SHALL be accepted when in_val && in_rdy && !flush; accept shifts register as {data[NBITS-2:0], in_bit} and increments count.
REQ-015: IDLE -> SHIFT on accept; SHIFT -> SHIFT on accept while count < NBITS-1; SHIFT -> FULL on the accept of bit NBITS.
REQ-016: On entering FULL, count SHALL wrap to 0; out_val SHALL be 1 in the cycle after the NBITS-th accept (latency 1 cycle).
REQ-017: out_val SHALL be 1 only in FULL; out_data SHALL be stable while out_val && !out_rdy.
REQ-018: FULL -> IDLE on out_val && out_rdy; the shift register need not clear; no bit is accepted in that cycle.
REQ-019: in_val without in_rdy, or in_val == 0, SHALL leave register, count and state unchanged.
REQ-020: flush SHALL force IDLE, count 0 and shift register 0 on the next edge from any state; flush overrides accept.
REQ-021: flush in FULL with out_rdy=1 in the same cycle SHALL count as a completed transfer, then IDLE.
REQ-022: out_data SHALL equal the shift register contents in all states (partial words visible, qualified by out_val).

Reset
REQ-023: reset low SHALL immediately force IDLE, count 0, shift register 0, out_val 0, in_rdy 1, independent of clk.
REQ-024: Reset asserted mid-word or in FULL SHALL discard the word with no out_val pulse.
REQ-025: After reset deasserts, the first accept SHALL occur no earlier than the first rising edge with reset high.

Structure
REQ-026: A shared package SHALL hold the state enum (IDLE, SHIFT, FULL) and default NBITS constant.
REQ-027: The shift register SHALL be one sub-module, sipo_sreg (clk, reset, clr, en, sin, pout[NBITS]); the controller drives en and clr.
REQ-028: Counter and FSM SHALL live in sipo_deser_ctrl; no other sub-modules.

Verification
REQ-029: Reset, then 8 accepted bits 1,0,1,0,1,0,1,0 with out_rdy=1 -> out_val=1 one cycle after last accept, out_data=0xAA, IDLE next cycle.
REQ-030: Complete word 0x0F with out_rdy=0 for 5 cycles while in_val=1 -> in_rdy=0, out_data held 0x0F throughout, bits not consumed; out_rdy=1 -> IDLE.
REQ-031: Accept 3 ones, flush=1 with in_val=1, then 8 bits 0,0,0,0,0,0,0,1 -> count 0 after flush, final out_data=0x01.
REQ-032: Accept 5 bits, assert reset low mid-cycle -> out_val=0, count=0, out_data=0x00 immediately, before next edge.
REQ-033: in_val toggling every other cycle across 8 accepts of 1 -> out_data=0xFF after 8th accept only; count tracks accepts exactly.
REQ-034: 200 cycles random in_val/in_bit/out_rdy/flush (flush 5%) -> cycle-accurate match to reference model on all outputs.

Source files
------------

// File: rtl/sipo_deser_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
package sipo_deser_ctrl_pkg;

  localparam int NBITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/sipo_sreg.sv
// Shift register: MSB-first accumulation, clear has priority over shift.
module sipo_sreg #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  output logic [NBITS-1:0] pout
);

  logic [NBITS-1:0] data_q;
  logic [NBITS-1:0] data_d;

  // next contents: clear, shift in new LSB, or hold
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = {NBITS{1'b0}};
    end else if (en) begin
      data_d = {data_q[NBITS-2:0], sin};
    end else begin
      data_d = data_q;
    end
  end

  // storage with async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= {NBITS{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign pout = data_q;

endmodule

// File: rtl/sipo_deser_ctrl.sv
// Deserializer controller: bit counter and IDLE/SHIFT/FULL handshake FSM
// around the sipo_sreg shift register.
module sipo_deser_ctrl
  import sipo_deser_ctrl_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  input  logic                     in_bit,
  output logic                     in_rdy,
  input  logic                     flush,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [NBITS-1:0]         out_data,
  output logic [$clog2(NBITS)-1:0] count
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            accept_s;

  assign accept_s = in_val && in_rdy && !flush;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; flush overrides everything, including a FULL handoff
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (accept_s && (count_q == LAST)) begin
          state_d = FULL;
        end else begin
          state_d = SHIFT;
        end
      end
      FULL: begin
        if (flush || out_rdy) begin
          state_d = IDLE;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // handshake outputs decoded from state alone
  always_comb begin
    in_rdy  = 1'b1;
    out_val = 1'b0;
    case (state_q)
      IDLE, SHIFT: begin
        in_rdy  = 1'b1;
        out_val = 1'b0;
      end
      FULL: begin
        in_rdy  = 1'b0;
        out_val = 1'b1;
      end
      default: begin
        in_rdy  = 1'b1;
        out_val = 1'b0;
      end
    endcase
  end

  // bit counter wraps to 0 as the word completes
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = {CW{1'b0}};
    end else if (accept_s) begin
      if (count_q == LAST) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  sipo_sreg #(
    .NBITS(NBITS)
  ) u_sreg (
    .clk  (clk),
    .reset(reset),
    .clr  (flush),
    .en   (accept_s),
    .sin  (in_bit),
    .pout (out_data)
  );

endmodule

// File: tb/tb_sipo_deser_ctrl.sv
// Self-checking bench: word-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sipo_deser_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         in_val;
  logic         in_bit;
  logic         in_rdy;
  logic         flush;
  logic         out_val;
  logic         out_rdy;
  logic [N-1:0] out_data;
  logic [2:0]   count;

  int tests = 0;
  int fails = 0;

  // reference model: current word value, bits held, word-complete flag
  int m_word = 0;
  int m_n    = 0;
  bit m_full = 1'b0;

  sipo_deser_ctrl #(.NBITS(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_bit  (in_bit),
    .in_rdy  (in_rdy),
    .flush   (flush),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_data(out_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model update: a word is an integer built MSB-first, held until taken
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_word <= 0;
      m_n    <= 0;
      m_full <= 1'b0;
    end else if (flush) begin
      m_word <= 0;
      m_n    <= 0;
      m_full <= 1'b0;
    end else if (m_full) begin
      if (out_rdy) m_full <= 1'b0;
    end else if (in_val) begin
      m_word <= (m_word * 2 + int'(in_bit)) % (1 << N);
      if (m_n + 1 == N) begin
        m_n    <= 0;
        m_full <= 1'b1;
      end else begin
        m_n <= m_n + 1;
      end
    end
  end

  // compare process: all outputs against the model, mid-cycle
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("m_in_rdy",   in_rdy,   !m_full);
      chk("m_out_val",  out_val,  m_full);
      chk("m_out_data", out_data, m_word);
      chk("m_count",    count,    m_n);
    end
  end

  task automatic drive(input logic v, input logic b, input logic r, input logic f);
    in_val  = v;
    in_bit  = b;
    out_rdy = r;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    int acc;
    reset = 1'b0; in_val = 1'b0; in_bit = 1'b0; out_rdy = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_val", out_val, 0);
    chk("rst_in_rdy",  in_rdy, 1);
    chk("rst_count",   count, 0);
    chk("rst_data",    out_data, 0);
    reset = 1'b1;

    // 0xAA with consumer ready
    pat = 8'hAA;
    for (int i = 7; i >= 0; i--) drive(1'b1, pat[i], 1'b1, 1'b0);
    chk("aa_out_val", out_val, 1);
    chk("aa_data",    out_data, 8'hAA);
    chk("aa_count",   count, 0);
    chk("aa_in_rdy",  in_rdy, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("aa_idle_val", out_val, 0);
    chk("aa_idle_rdy", in_rdy, 1);

    // 0x0F held under backpressure
    pat = 8'h0F;
    for (int i = 7; i >= 0; i--) drive(1'b1, pat[i], 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("bp_in_rdy", in_rdy, 0);
      chk("bp_data",   out_data, 8'h0F);
      chk("bp_count",  count, 0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("bp_rel_val",  out_val, 0);
    chk("bp_rel_data", out_data, 8'h0F);
    chk("bp_rel_cnt",  count, 0);

    // flush mid-word, then 0x01
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("fl_pre_cnt", count, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("fl_cnt",  count, 0);
    chk("fl_data", out_data, 0);
    pat = 8'h01;
    for (int i = 7; i >= 0; i--) drive(1'b1, pat[i], 1'b0, 1'b0);
    chk("fl_word", out_data, 8'h01);
    chk("fl_val",  out_val, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-word
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("ar_val",  out_val, 0);
    chk("ar_cnt",  count, 0);
    chk("ar_data", out_data, 0);
    chk("ar_rdy",  in_rdy, 1);
    @(posedge clk);
    #1 reset = 1'b1;

    // in_val every other cycle
    acc = 0;
    for (int i = 0; i < 15; i++) begin
      drive((i % 2) == 0, 1'b1, 1'b0, 1'b0);
      if ((i % 2) == 0) acc++;
      chk("alt_cnt", count, acc % 8);
      chk("alt_val", out_val, acc == 8);
      chk("alt_data", out_data, (acc == 8) ? 8'hFF : ((1 << acc) - 1));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // random traffic, flush about 5%
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
            ($urandom_range(0, 99) < 5));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
